// File: rtl/chunked_accumulator.sv
// chunked_accumulator
//   Switch accumulator with a multi-cycle adder. Each rising edge of
//   Run_Accumulate adds (or, in Sub mode, subtracts) the zero-extended SW
//   operand to a running total, CHUNK bits per clock. Carry and sticky signed
//   overflow are tracked, and the total drives active-low 7-segment digits.
//
// Ports
//   Clk            in   system clock, rising edge
//   Reset_Clear    in   asynchronous active-high reset, clears all state
//   Run_Accumulate in   asynchronous key level; rising edge starts one operation
//   Sub            in   0 = add, 1 = subtract; sampled at operation start
//   SW             in   operand, zero-extended; sampled at operation start
//   Sum            out  {carry of last op, accumulator}
//   Busy           out  operation in progress
//   Done           out  one-cycle pulse when Sum updates
//   Overflow       out  sticky signed overflow
//   HEX            out  active-low digits, digit i = HEX[7i+6:7i] shows Sum[4i+3:4i]
module chunked_accumulator #(
   parameter int unsigned IN_WIDTH  = 10,
   parameter int unsigned ACC_WIDTH = 16,
   parameter int unsigned CHUNK     = 4
) (
   input  logic                           Clk,
   input  logic                           Reset_Clear,
   input  logic                           Run_Accumulate,
   input  logic                           Sub,
   input  logic [IN_WIDTH-1:0]            SW,
   output logic [ACC_WIDTH:0]             Sum,
   output logic                           Busy,
   output logic                           Done,
   output logic                           Overflow,
   output logic [7*(ACC_WIDTH/4+1)-1:0]   HEX
);

   localparam int unsigned NCH     = ACC_WIDTH / CHUNK;
   localparam int unsigned NUM_HEX = ACC_WIDTH / 4 + 1;
   localparam int unsigned CW      = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CW-1:0] LastCh = CW'(NCH - 1);

   typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

   state_e                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [ACC_WIDTH-1:0]   op_q, op_d;
   logic                   carry_q, carry_d;
   logic [ACC_WIDTH:0]     sum_q, sum_d;
   logic                   ovf_q, ovf_d;
   logic                   s1_q, s2_q, s3_q;

   logic                   run_edge;
   logic [ACC_WIDTH-1:0]   op_ext;
   logic [CHUNK:0]         chunk_sum;

   assign run_edge = s2_q & ~s3_q;
   assign op_ext   = ACC_WIDTH'(SW);

   // acc_q and op_q rotate right by CHUNK each ADD cycle, so the chunk being
   // processed is always at the bottom; after NCH cycles acc_q is back in order
   // and on the last cycle the bottom chunks hold the original MSBs.
   assign chunk_sum = {1'b0, acc_q[CHUNK-1:0]} + {1'b0, op_q[CHUNK-1:0]}
                      + (CHUNK+1)'(carry_q);

   always_ff @(posedge Clk or posedge Reset_Clear) begin
      if (Reset_Clear) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         acc_q   <= '0;
         op_q    <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
         // Preset high so a key held through reset produces no edge.
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         s3_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         op_q    <= op_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         ovf_q   <= ovf_d;
         s1_q    <= Run_Accumulate;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      op_d    = op_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (run_edge) begin
               op_d    = Sub ? ~op_ext : op_ext;
               carry_d = Sub;
               cnt_d   = '0;
               acc_d   = sum_q[ACC_WIDTH-1:0];
               state_d = StAdd;
            end
         end
         StAdd: begin
            acc_d   = ACC_WIDTH'({chunk_sum[CHUNK-1:0], acc_q} >> CHUNK);
            op_d    = op_q >> CHUNK;
            carry_d = chunk_sum[CHUNK];
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LastCh) begin
               sum_d = {chunk_sum[CHUNK], acc_d};
               // Operands share a sign but the result sign differs.
               if ((acc_q[CHUNK-1] == op_q[CHUNK-1]) &&
                   (chunk_sum[CHUNK-1] != acc_q[CHUNK-1])) begin
                  ovf_d = 1'b1;
               end
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign Sum      = sum_q;
   assign Busy     = (state_q != StIdle);
   assign Done     = (state_q == StDone);
   assign Overflow = ovf_q;

   function automatic logic [6:0] seg7(input logic [3:0] v);
      logic [6:0] s;
      s = 7'b1000000;
      unique case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         4'hF: s = 7'b0001110;
         default: s = 7'b1000000;
      endcase
      return s;
   endfunction

   logic [4*NUM_HEX-1:0] sum_pad;
   assign sum_pad = (4*NUM_HEX)'(sum_q);

   for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
      assign HEX[7*i +: 7] = seg7(sum_pad[4*i +: 4]);
   end

endmodule

// File: doc/chunked_accumulator.md
Name: chunked_accumulator

Overview:
- Parametrised successor to the lab switch-accumulator: on each rising edge of Run_Accumulate it adds the zero-extended SW operand to a running total, or subtracts it in Sub mode.
- The adder is multi-cycle: it processes CHUNK bits per clock, and its carry and signed overflow are tracked.
- Sits between the board switches/keys and the seven-segment displays. It drives active-low HEX digits directly.

Parameters:
- IN_WIDTH, 10, switch operand width; must be ≤ ACC_WIDTH.
- ACC_WIDTH, 16, accumulator register width; must be a multiple of 4 and of CHUNK.
- CHUNK, 4, bits added per clock. NCH = ACC_WIDTH/CHUNK.
- NUM_HEX = ACC_WIDTH/4 + 1 (derived, localparam).

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset_Clear  in  1  asynchronous, active-high reset; clears all state.
- Run_Accumulate  in  1  asynchronous level from key; its rising edge starts one operation.
- Sub  in  1  0 = add, 1 = subtract; sampled at operation start.
- SW  in  IN_WIDTH  operand, zero-extended; sampled at operation start.
- Sum  out  ACC_WIDTH+1  {carry of last op, accumulator}.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse when Sum updates.
- Overflow  out  1  sticky signed overflow.
- HEX  out  7*NUM_HEX  active-low 7-seg. Digit i is at [7i+6:7i] and shows Sum[4i+3:4i], zero-padded for the top digit.

Behaviour:
- Reset (async assert, any state):
  - Sum = 0, Busy = 0, Done = 0, Overflow = 0, FSM = IDLE.
  - Working registers = 0.
  - Synchronizer flops s1/s2/s3 = 1, so a key held through reset never triggers.
  - Any in-flight operation is discarded.
- Input sync:
  - Run_Accumulate passes through s1→s2→s3.
  - run_edge = s2 & ~s3, high for exactly one cycle per rising edge.
- FSM states: IDLE, ADD, DONE.
  - IDLE: on run_edge, capture op = zext(SW) (bitwise-inverted if Sub), capture Sub, set carry_in = Sub, chunk counter = 0, go to ADD. Busy goes 1 at this edge.
  - ADD: each cycle adds chunk k of the working accumulator, op and the carry; stores the result chunk and carry-out; k++.
  - ADD, final chunk (k = NCH-1): commit the working accumulator and carry to Sum, update Overflow, go to DONE.
  - DONE: Done = 1 for this single cycle, Busy still 1; next state IDLE, where Busy = 0.
- Timing with first edge sampling Run high = edge 1:
  - run_edge is valid after edge 2; capture at edge 3.
  - Chunks are processed at edges 4..3+NCH.
  - Sum and Done update at edge 3+NCH (edge 7 at defaults).
  - Busy falls at edge 4+NCH.
- Sum visibility:
  - Sum changes only at commit; partial results are never visible.
  - The working accumulator is loaded from Sum[ACC_WIDTH-1:0] at capture.
- Arithmetic:
  - Add: A + op.
  - Sub: A + ~op + 1, i.e. two's complement.
  - Sum[ACC_WIDTH] = carry out of the MSB chunk (in Sub, 1 = no borrow).
  - The accumulator wraps modulo 2^ACC_WIDTH.
- Overflow:
  - Set when A and the effective op (~op for Sub) have the same MSB and the result MSB differs.
  - Sticky until reset.
- Boundaries:
  - A Run edge arriving in ADD or DONE is dropped, not queued.
  - Run held high yields exactly one operation.
  - SW or Sub changes after capture have no effect on the in-flight op.
- HEX:
  - Combinational from Sum.
  - Segment map 0..F standard, active-low; "0" = 7'b1000000.

Test Plan:
- Reset, then SW=0x3FF, Sub=0, pulse Run (6 cycles) → Sum=0x003FF at edge 7, Done 1 cycle, Busy 4 cycles + Done cycle. HEX0 shows F, HEX1 F, HEX2 3, HEX3/HEX4 0.
- 32 add runs of 0x3FF → Sum=0x07FE0, Overflow=0. The 33rd run → Sum=0x083DF (carry 0), Overflow=1 and stays 1 through further ops.
- Run until accumulator = 0xFFC0 (64 runs of 0x3FF), then one more → Sum=0x103BF (carry=1, wrap).
- After reset, Sub=1, SW=0x001 → Sum=0x0FFFF (carry 0 = borrow), Overflow=0. Then Sub=0, SW=0x001 → Sum=0x10000.
- Run held high 200 cycles with SW=0x005 → exactly one Done, Sum=0x00005. A second Run pulse landing inside ADD → ignored, Sum unchanged.
- Reset_Clear asserted asynchronously mid-ADD → Sum, Busy, Done and Overflow are 0 immediately. With Run held high across reset release → no operation starts.
